// File: rtl/sram_burst_ctrl_pkg.sv
// rtl/sram_burst_ctrl_pkg.sv - shared FSM encodings and burst constants for sram_burst_ctrl
// Optional feature macro: SRAM_WAIT_STATE_EN (two cycles per SRAM beat)
package sram_burst_ctrl_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int WR_BEATS = 2;
    localparam int RD_BEATS = 4;

`ifdef SRAM_WAIT_STATE_EN
    localparam int BEAT_CYCLES = 2;
`else
    localparam int BEAT_CYCLES = 1;
`endif

    function automatic logic is_last_beat(input logic [1:0] state, input logic [1:0] k);
        return ((state == WR) && (k == 2'(WR_BEATS - 1))) ||
               ((state == RD) && (k == 2'(RD_BEATS - 1)));
    endfunction

endpackage

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - 16-bit async SRAM controller: 32-bit word writes, 64-bit line reads
// Optional feature macro: SRAM_WAIT_STATE_EN (each beat held for two cycles)
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [63:0]       rdata,
    output logic              ready,
    output logic              busy,
    inout  wire  [15:0]       sram_dq,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n
);

    logic [1:0]      r_state;
    logic [1:0]      r_k;
    logic [ADDR_W:2] r_addr;
    logic [31:0]     r_wdata;
    logic [63:0]     r_rdata;
    logic            w_beat_end;
    logic            w_last;
    logic [15:0]     w_wr_half;
    logic            w_unused;

    assign w_unused = ^{addr[31:ADDR_W+1], addr[1:0]};

`ifdef SRAM_WAIT_STATE_EN
    logic r_phase;

    // Phase 0 sets up address/controls, phase 1 completes the beat.
    always_ff @(posedge clk) begin
        if (rst || !((r_state == WR) || (r_state == RD))) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign w_beat_end = r_phase;
`else
    assign w_beat_end = 1'b1;
`endif

    assign w_last = is_last_beat(r_state, r_k);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_rdata <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_k <= 2'd0;
                    if (wr_en) begin
                        r_state <= WR;
                    end else if (rd_en) begin
                        r_state <= RD;
                    end
                end
                WR, RD: begin
                    if (w_beat_end) begin
                        if (r_state == RD) begin
                            r_rdata[{r_k, 4'b0000} +: 16] <= sram_dq;
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_k     <= 2'd0;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Request operands are snapshotted while idle so a careless requester cannot corrupt a burst.
    always_ff @(posedge clk) begin
        if (r_state == IDLE) begin
            r_addr  <= addr[ADDR_W:2];
            r_wdata <= wdata;
        end
    end

    assign w_wr_half = r_k[0] ? r_wdata[31:16] : r_wdata[15:0];

    always_comb begin
        sram_addr = '0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        case (r_state)
            WR: begin
                sram_addr = {r_addr[ADDR_W:2], r_k[0]};
                sram_we_n = 1'b0;
            end
            RD: begin
                sram_addr = {r_addr[ADDR_W:3], r_k};
                sram_oe_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign sram_dq   = (r_state == WR) ? w_wr_half : 16'bz;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign rdata = r_rdata;
    assign ready = (r_state == DONE);
    // Dropping busy in DONE lets the pipeline advance on the same edge that retires the access.
    assign busy  = ((r_state == IDLE) && (wr_en || rd_en)) || (r_state == WR) || (r_state == RD);

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 18, width of the SRAM halfword address.
REQ-002 The block SHALL have port clk, input, 1 bit: clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port wr_en, input, 1 bit: 32-bit word write request, held stable by the requester while busy.
REQ-005 The block SHALL have port rd_en, input, 1 bit: 64-bit line read request, held stable by the requester while busy.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address, already offset by the memory stage.
REQ-007 The block SHALL have port wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port rdata, output, 64 bits: assembled read line, registered.
REQ-009 The block SHALL have port ready, output, 1 bit: one-cycle pulse indicating rdata is valid or the write is complete.
REQ-010 The block SHALL have port busy, output, 1 bit: pipeline freeze request.
REQ-011 The block SHALL have port sram_dq, inout, 16 bits: SRAM data bus.
REQ-012 The block SHALL have port sram_addr, output, ADDR_W bits: SRAM halfword address.
REQ-013 The block SHALL have ports sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n and sram_oe_n, each output, 1 bit, all active-low SRAM controls.

Function
REQ-014 The FSM SHALL have the states IDLE, WR, RD and DONE, with a 2-bit beat counter k.
REQ-015 In IDLE, a sampled wr_en SHALL move the FSM to WR with k=0, and a sampled rd_en SHALL move it to RD with k=0.
REQ-016 If wr_en and rd_en are both set in IDLE, the write SHALL be taken and the read ignored.
REQ-017 WR SHALL perform 2 beats (k=0..1) and RD SHALL perform 4 beats (k=0..3); after the last beat the FSM SHALL go to DONE.
REQ-018 DONE SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-019 busy SHALL equal (IDLE and (wr_en or rd_en)) or WR or RD; it SHALL be combinational and SHALL be 0 in DONE, so the pipeline advances on that edge.
REQ-020 Write beat k SHALL use sram_addr = {addr[ADDR_W:2], k[0]}, drive sram_dq = wdata[16k+15:16k], and hold sram_we_n=0 and sram_oe_n=1.
REQ-021 Read beat k SHALL use sram_addr = {addr[ADDR_W:3], k[1:0]}, hold sram_oe_n=0 and sram_we_n=1, leave sram_dq at high-Z, and capture sram_dq into rdata[16k+15:16k] at the end of the beat.
REQ-022 sram_ce_n, sram_ub_n and sram_lb_n SHALL be held at 0 at all times.
REQ-023 Outside WR, sram_we_n SHALL be 1 and sram_dq SHALL be high-Z.
REQ-024 With the request seen at cycle T, ready SHALL pulse at T+3 for a write and at T+5 for a read (no wait states).
REQ-025 rdata SHALL hold its value until the next read completes; a write SHALL not alter rdata.
REQ-026 A request deasserted mid-operation SHALL be ignored; the operation SHALL finish as started.

Reset
REQ-027 On rst, the block SHALL go to state IDLE with k=0, rdata=0, ready=0, busy=0 (given no request), sram_addr=0, sram_we_n=1, sram_oe_n=1 and sram_dq at high-Z.
REQ-028 rst asserted mid-operation SHALL abort the operation, produce no ready pulse, and leave the rdata bits already captured cleared.

Configuration
REQ-029 With SRAM_WAIT_STATE_EN defined, each beat SHALL occupy 2 cycles: address and controls are held for both cycles, read capture occurs in the second cycle, and ready pulses at T+5 for a write and T+9 for a read.
REQ-030 Without SRAM_WAIT_STATE_EN, each beat SHALL occupy 1 cycle with the timing of REQ-024.

Structure
REQ-031 A shared package/include SHALL hold the state encodings (IDLE=0, WR=1, RD=2, DONE=3) and the constants WR_BEATS=2 and RD_BEATS=4.
REQ-032 The block SHALL be a single module with the FSM, beat counter and tristate control inline; no sub-module is needed.

Verification
REQ-033 Write: addr=0x0000_0008, wdata=0xDEAD_BEEF -> beat 0 drives sram_addr=0x00004 with dq=0xBEEF and beat 1 drives 0x00005 with dq=0xDEAD; ready pulses at T+3 and busy is high T..T+2.
REQ-034 Read after write: read addr=0x0000_000C on an SRAM model preloaded with halfwords 1,2,3,4 at 0x4..0x7 -> sram_addr sequence 4,5,6,7 and rdata=0x0004_0003_0002_0001 at T+5.
REQ-035 Simultaneous wr_en=1 and rd_en=1 -> only the write sequence runs, sram_oe_n stays 1 throughout, and rdata is unchanged.
REQ-036 rst asserted at read beat 2 -> no ready pulse, rdata=0, FSM in IDLE, and sram_dq at Z on the next cycle.
REQ-037 SRAM_WAIT_STATE_EN defined -> each sram_addr value is held 2 cycles, a read is ready at T+9 and a write at T+5.
REQ-038 Back-to-back requests: a read presented the cycle after DONE -> busy rises that same cycle with no idle gap beyond the DONE cycle.
